// File: rtl/ram_block_copier_pkg.sv
// Shared memory-utility constants: copier FSM encoding, operating modes and
// default geometry of the single-port RAM instances in this codebase.
package ram_block_copier_pkg;

    localparam int STATE_BITS = 3;

    localparam logic [STATE_BITS-1:0] ST_IDLE = 3'd0;
    localparam logic [STATE_BITS-1:0] ST_RD   = 3'd1;
    localparam logic [STATE_BITS-1:0] ST_CAP  = 3'd2;
    localparam logic [STATE_BITS-1:0] ST_WR   = 3'd3;
    localparam logic [STATE_BITS-1:0] ST_FIN  = 3'd4;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    localparam int RAM_ADDR_BITS_DEFAULT = 10;
    localparam int RAM_DATA_BITS_DEFAULT = 8;

endpackage

// File: rtl/ram_block_copier.sv
// Block copy / fill initiator for a single-port synchronous RAM with a
// one-cycle registered read. Every output is a register loaded for the next cycle.
module ram_block_copier
    import ram_block_copier_pkg::*;
#(
    parameter int ADDR_BITS = RAM_ADDR_BITS_DEFAULT,
    parameter int DATA_BITS = RAM_DATA_BITS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 mode,
    input  logic [ADDR_BITS-1:0] src_addr,
    input  logic [ADDR_BITS-1:0] dst_addr,
    input  logic [ADDR_BITS:0]   len,
    input  logic [DATA_BITS-1:0] fill_data,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic                 ram_ena,
    output logic                 ram_wea,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic [DATA_BITS-1:0] ram_din,
    input  logic [DATA_BITS-1:0] ram_dout
);

    logic [STATE_BITS-1:0] state;
    logic [ADDR_BITS:0]    idx;
    logic [ADDR_BITS:0]    count_q;
    logic [ADDR_BITS-1:0]  src_q;
    logic [ADDR_BITS-1:0]  dst_q;
    logic                  mode_q;
    logic [DATA_BITS-1:0]  fill_q;

    logic [ADDR_BITS:0]    idx_next;
    logic [ADDR_BITS-1:0]  src_next;
    logic [ADDR_BITS-1:0]  dst_cur;
    logic [ADDR_BITS-1:0]  dst_next;
    logic                  last_word;

    // Address sums drop the carry so both windows wrap around the RAM.
    always_comb begin
        idx_next  = idx + 1'b1;
        src_next  = src_q + idx_next[ADDR_BITS-1:0];
        dst_cur   = dst_q + idx[ADDR_BITS-1:0];
        dst_next  = dst_q + idx_next[ADDR_BITS-1:0];
        last_word = (idx_next == count_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            idx      <= '0;
            count_q  <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            mode_q   <= MODE_COPY;
            fill_q   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            aborted  <= 1'b0;
            ram_ena  <= 1'b0;
            ram_wea  <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
        end else begin
            done    <= 1'b0;
            ram_ena <= 1'b0;
            ram_wea <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        count_q <= len;
                        src_q   <= src_addr;
                        dst_q   <= dst_addr;
                        mode_q  <= mode;
                        fill_q  <= fill_data;
                        idx     <= '0;
                        aborted <= 1'b0;
                        if (len == '0) begin
                            state <= ST_FIN;
                            done  <= 1'b1;
                        end else if (mode == MODE_COPY) begin
                            state    <= ST_RD;
                            busy     <= 1'b1;
                            ram_ena  <= 1'b1;
                            ram_addr <= src_addr;
                        end else begin
                            state    <= ST_WR;
                            busy     <= 1'b1;
                            ram_ena  <= 1'b1;
                            ram_wea  <= 1'b1;
                            ram_addr <= dst_addr;
                            ram_din  <= fill_data;
                        end
                    end
                end
                ST_RD: begin
                    if (abort) begin
                        state   <= ST_FIN;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end else begin
                        state <= ST_CAP;
                    end
                end
                // Read data is on ram_dout now; it goes straight into the write register.
                ST_CAP: begin
                    if (abort) begin
                        state   <= ST_FIN;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end else begin
                        state    <= ST_WR;
                        ram_ena  <= 1'b1;
                        ram_wea  <= 1'b1;
                        ram_addr <= dst_cur;
                        ram_din  <= ram_dout;
                    end
                end
                ST_WR: begin
                    idx <= idx_next;
                    if (abort || last_word) begin
                        state   <= ST_FIN;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        aborted <= abort;
                    end else if (mode_q == MODE_COPY) begin
                        state    <= ST_RD;
                        ram_ena  <= 1'b1;
                        ram_addr <= src_next;
                    end else begin
                        state    <= ST_WR;
                        ram_ena  <= 1'b1;
                        ram_wea  <= 1'b1;
                        ram_addr <= dst_next;
                        ram_din  <= fill_q;
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_block_copier.sv
// Directed bench for ram_block_copier; a behavioural write-first single-port
// RAM with a backdoor port stands in for the real RAM instance.
module tb_ram_block_copier;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic [9:0] src_addr = '0;
    logic [9:0] dst_addr = '0;
    logic [10:0] len = '0;
    logic [7:0] fill_data = '0;
    logic       abort = 1'b0;
    logic       busy, done, aborted, ram_ena, ram_wea;
    logic [9:0] ram_addr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout = '0;

    logic [7:0] mem [1024];
    logic       bd_init = 1'b0;
    logic       bd_we = 1'b0;
    logic [9:0] bd_addr = '0;
    logic [7:0] bd_data = '0;

    int checks = 0;
    int errors = 0;
    int cyc;
    int ena_cnt, wea_cnt, busy_cnt, wea_bad, run, run_max;
    logic [9:0] rd_q[$];
    logic [9:0] wr_q[$];

    ram_block_copier #(.ADDR_BITS(10), .DATA_BITS(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_data(fill_data),
        .abort(abort), .busy(busy), .done(done), .aborted(aborted),
        .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] bg(input int a);
        logic [7:0] v;
        v = 8'(a);
        return v ^ 8'h3C;
    endfunction

    // Write-first RAM port, plus a backdoor used only while the copier is idle.
    always @(posedge clk) begin
        if (ram_ena) begin
            if (ram_wea) begin
                mem[ram_addr] <= ram_din;
                ram_dout      <= ram_din;
            end else begin
                ram_dout <= mem[ram_addr];
            end
        end
        if (bd_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= bg(i);
        end else if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic init_mem();
        @(posedge clk); #1; bd_init = 1'b1;
        @(posedge clk); #1; bd_init = 1'b0;
    endtask

    task automatic poke(input logic [9:0] a, input logic [7:0] d);
        @(posedge clk); #1; bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(posedge clk); #1; bd_we = 1'b0;
    endtask

    // Drives start for one cycle; returns in cycle 1 of the operation.
    task automatic start_op(input logic m, input logic [9:0] s, input logic [9:0] d,
                            input logic [10:0] n, input logic [7:0] f);
        @(posedge clk); #1;
        start = 1'b1; mode = m; src_addr = s; dst_addr = d; len = n; fill_data = f;
        cyc = 0;
        ena_cnt = 0; wea_cnt = 0; busy_cnt = 0; wea_bad = 0; run = 0; run_max = 0;
        rd_q.delete();
        wr_q.delete();
        step();
        start = 1'b0;
    endtask

    task automatic observe();
        if (ram_ena) ena_cnt++;
        if (ram_ena && !ram_wea) rd_q.push_back(ram_addr);
        if (ram_ena && ram_wea) begin
            wr_q.push_back(ram_addr);
            wea_cnt++;
            run++;
            if (run > run_max) run_max = run;
        end else begin
            run = 0;
        end
        if (ram_wea && !ram_ena) wea_bad++;
        if (busy) busy_cnt++;
    endtask

    // Leaves cyc at the cycle done was seen, or at the limit when it never came.
    task automatic wait_done(input int limit);
        observe();
        while (!done && cyc < limit) begin
            step();
            observe();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, aborted, ram_ena, ram_wea} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags got %b want 00000", {busy, done, aborted, ram_ena, ram_wea});
        end
        checks++;
        if (ram_addr !== 10'h000 || ram_din !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_bus got addr=%h din=%h want 000/00", ram_addr, ram_din);
        end
        reset_n = 1'b1;
        init_mem();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, ram_ena, ram_wea} !== 4'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset got %b want 0000", {busy, done, ram_ena, ram_wea});
        end
    endtask

    task automatic test_copy();
        poke(10'h010, 8'hA1); poke(10'h011, 8'hB2); poke(10'h012, 8'hC3); poke(10'h013, 8'hD4);
        start_op(1'b0, 10'h010, 10'h200, 11'd4, 8'h00);
        wait_done(100);
        checks++;
        if (cyc !== 13) begin
            errors++;
            $display("[TB] FAIL copy_done_cycle got %0d want 13", cyc);
        end
        checks++;
        if ({mem[10'h200], mem[10'h201], mem[10'h202], mem[10'h203]} !== 32'hA1B2C3D4) begin
            errors++;
            $display("[TB] FAIL copy_dst got %h%h%h%h want a1b2c3d4",
                     mem[10'h200], mem[10'h201], mem[10'h202], mem[10'h203]);
        end
        checks++;
        if ({mem[10'h010], mem[10'h011], mem[10'h012], mem[10'h013]} !== 32'hA1B2C3D4) begin
            errors++;
            $display("[TB] FAIL copy_src got %h%h%h%h want a1b2c3d4",
                     mem[10'h010], mem[10'h011], mem[10'h012], mem[10'h013]);
        end
        checks++;
        if (mem[10'h204] !== bg(10'h204)) begin
            errors++;
            $display("[TB] FAIL copy_past_end got %h want %h", mem[10'h204], bg(10'h204));
        end
        checks++;
        if (ena_cnt !== 8 || wea_cnt !== 4 || wea_bad !== 0 || busy_cnt !== 12) begin
            errors++;
            $display("[TB] FAIL copy_counts got ena=%0d wea=%0d bad=%0d busy=%0d want 8/4/0/12",
                     ena_cnt, wea_cnt, wea_bad, busy_cnt);
        end
        checks++;
        if (busy !== 1'b0 || aborted !== 1'b0) begin
            errors++;
            $display("[TB] FAIL copy_done_flags got busy=%b aborted=%b want 0/0", busy, aborted);
        end
    endtask

    task automatic test_len_zero();
        start_op(1'b0, 10'h010, 10'h220, 11'd0, 8'h00);
        wait_done(20);
        checks++;
        if (cyc !== 1) begin
            errors++;
            $display("[TB] FAIL len0_done_cycle got %0d want 1", cyc);
        end
        repeat (3) begin
            step();
            observe();
        end
        checks++;
        if (ena_cnt !== 0 || busy_cnt !== 0) begin
            errors++;
            $display("[TB] FAIL len0_activity got ena=%0d busy=%0d want 0/0", ena_cnt, busy_cnt);
        end
    endtask

    task automatic test_wrap();
        poke(10'h3FE, 8'h11); poke(10'h3FF, 8'h22); poke(10'h000, 8'h33); poke(10'h001, 8'h44);
        start_op(1'b0, 10'h3FE, 10'h0FE, 11'd4, 8'h00);
        wait_done(100);
        checks++;
        if (rd_q.size() !== 4 || wr_q.size() !== 4) begin
            errors++;
            $display("[TB] FAIL wrap_access_count got rd=%0d wr=%0d want 4/4", rd_q.size(), wr_q.size());
        end else begin
            checks++;
            if ({rd_q[0], rd_q[1], rd_q[2], rd_q[3]} !== {10'h3FE, 10'h3FF, 10'h000, 10'h001}) begin
                errors++;
                $display("[TB] FAIL wrap_read_addr got %h %h %h %h want 3fe 3ff 000 001",
                         rd_q[0], rd_q[1], rd_q[2], rd_q[3]);
            end
            checks++;
            if ({wr_q[0], wr_q[1], wr_q[2], wr_q[3]} !== {10'h0FE, 10'h0FF, 10'h100, 10'h101}) begin
                errors++;
                $display("[TB] FAIL wrap_write_addr got %h %h %h %h want 0fe 0ff 100 101",
                         wr_q[0], wr_q[1], wr_q[2], wr_q[3]);
            end
        end
        checks++;
        if ({mem[10'h0FE], mem[10'h0FF], mem[10'h100], mem[10'h101]} !== 32'h11223344) begin
            errors++;
            $display("[TB] FAIL wrap_dst got %h%h%h%h want 11223344",
                     mem[10'h0FE], mem[10'h0FF], mem[10'h100], mem[10'h101]);
        end
    endtask

    task automatic test_abort();
        init_mem();
        start_op(1'b1, 10'h000, 10'h100, 11'd16, 8'h5A);
        step();
        step();
        start = 1'b1; mode = 1'b0; dst_addr = 10'h2A0; len = 11'd2; fill_data = 8'hEE;
        step();
        start = 1'b0;
        checks++;
        if (ram_addr !== 10'h103 || ram_wea !== 1'b1 || ram_din !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL busy_start_ignored got addr=%h wea=%b din=%h want 103/1/5a",
                     ram_addr, ram_wea, ram_din);
        end
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (done !== 1'b1 || aborted !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_done got done=%b aborted=%b busy=%b want 1/1/0", done, aborted, busy);
        end
        checks++;
        if ({mem[10'h100], mem[10'h101], mem[10'h102], mem[10'h103], mem[10'h104]} !== 40'h5A5A5A5A5A ||
            mem[10'h105] !== bg(10'h105)) begin
            errors++;
            $display("[TB] FAIL abort_mem got 104=%h 105=%h want 5a/%h", mem[10'h104], mem[10'h105], bg(10'h105));
        end
        step();
        checks++;
        if (done !== 1'b0 || aborted !== 1'b1 || ram_ena !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_level got done=%b aborted=%b ena=%b want 0/1/0", done, aborted, ram_ena);
        end
        start_op(1'b1, 10'h000, 10'h180, 11'd0, 8'h00);
        wait_done(20);
        checks++;
        if (aborted !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL aborted_clear got aborted=%b done=%b want 0/1", aborted, done);
        end
    endtask

    task automatic test_fill();
        start_op(1'b1, 10'h000, 10'h000, 11'h400, 8'h00);
        wait_done(2000);
        checks++;
        if (cyc !== 1025) begin
            errors++;
            $display("[TB] FAIL fill_done_cycle got %0d want 1025", cyc);
        end
        checks++;
        if (wea_cnt !== 1024 || run_max !== 1024) begin
            errors++;
            $display("[TB] FAIL fill_wea_run got count=%0d run=%0d want 1024/1024", wea_cnt, run_max);
        end
        begin
            int nonzero = 0;
            for (int i = 0; i < 1024; i++) if (mem[i] !== 8'h00) nonzero++;
            checks++;
            if (nonzero !== 0) begin
                errors++;
                $display("[TB] FAIL fill_mem got %0d nonzero words want 0", nonzero);
            end
        end
    endtask

    task automatic test_reset_midop();
        init_mem();
        start_op(1'b0, 10'h010, 10'h300, 11'd4, 8'h00);
        repeat (3) step();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, aborted, ram_ena, ram_wea} !== 5'b0 || ram_addr !== 10'h000 || ram_din !== 8'h00) begin
            errors++;
            $display("[TB] FAIL async_reset got flags=%b addr=%h din=%h want 0/000/00",
                     {busy, done, aborted, ram_ena, ram_wea}, ram_addr, ram_din);
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        checks++;
        if (mem[10'h300] !== bg(10'h010) || mem[10'h301] !== bg(10'h301)) begin
            errors++;
            $display("[TB] FAIL partial_write got 300=%h 301=%h want %h/%h",
                     mem[10'h300], mem[10'h301], bg(10'h010), bg(10'h301));
        end
        start_op(1'b1, 10'h000, 10'h310, 11'd3, 8'h77);
        wait_done(50);
        checks++;
        if (cyc !== 4) begin
            errors++;
            $display("[TB] FAIL post_reset_done_cycle got %0d want 4", cyc);
        end
        checks++;
        if ({mem[10'h310], mem[10'h311], mem[10'h312]} !== 24'h777777 || mem[10'h313] !== bg(10'h313)) begin
            errors++;
            $display("[TB] FAIL post_reset_fill got %h%h%h next=%h want 777777/%h",
                     mem[10'h310], mem[10'h311], mem[10'h312], mem[10'h313], bg(10'h313));
        end
    endtask

    initial begin
        test_reset();
        test_len_zero();
        test_copy();
        test_wrap();
        test_abort();
        test_fill();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
